// File: rtl/mem_master_pkg.sv
// Shared definitions for the mem_master RAM initiator: state encoding,
// byte-lane constants and the lane selection helper.
package mem_master_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_e;

  localparam int unsigned LANE_LO    = 0;
  localparam int unsigned LANE_HI    = 1;
  localparam int unsigned WORD_BYTES = 2;

  // Little-endian lane pick: lane 0 is the low byte of the 16-bit word.
  function automatic logic [7:0] lane_byte(input logic [15:0] data, input logic lane);
    return lane ? data[15:8] : data[7:0];
  endfunction

endpackage

// File: rtl/mem_master_wait_timer.sv
// Per-byte WAIT watchdog: cleared when a byte is issued, counts WAIT cycles,
// and flags the last permitted cycle before the transaction is abandoned.
module mem_master_wait_timer #(
  parameter int unsigned timeout = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(timeout);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == CW'(timeout - 1));

endmodule

// File: rtl/mem_master.sv
// CPU-side initiator for the RAM read/write/ready handshake: splits byte and
// 16-bit little-endian word requests into one-byte RAM transactions.
module mem_master
  import mem_master_pkg::*;
#(
  parameter int unsigned size_addr = 8,
  parameter int unsigned timeout   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic                 cpu_word,
  input  logic [size_addr-1:0] cpu_addr,
  input  logic [15:0]          cpu_wdata,
  output logic                 cpu_busy,
  output logic                 cpu_done,
  output logic                 cpu_err,
  output logic [15:0]          cpu_rdata,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [size_addr-1:0] mem_address,
  output logic [7:0]           mem_data_in,
  input  logic [7:0]           mem_data_out,
  input  logic                 mem_ready_r,
  input  logic                 mem_ready_w
);

  state_e               state_q, state_d;
  logic                 we_q, we_d;
  logic                 word_q, word_d;
  logic                 idx_q, idx_d;
  logic [size_addr-1:0] addr_q, addr_d;
  logic [15:0]          wdata_q, wdata_d;
  logic [15:0]          shadow_q, shadow_d;
  logic [15:0]          rdata_q, rdata_d;
  logic                 match;
  logic                 last_byte;
  logic                 expired;

  // Only the ready that belongs to the current direction completes a byte.
  assign match     = we_q ? mem_ready_w : mem_ready_r;
  assign last_byte = word_q ? (idx_q == 1'(WORD_BYTES - 1)) : 1'b1;

  mem_master_wait_timer #(.timeout(timeout)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q == ISSUE),
    .enable  (state_q == WAIT),
    .expired (expired)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cpu_req) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT: begin
        if (match)        state_d = last_byte ? DONE : ISSUE;
        else if (expired) state_d = ERR;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    cpu_done  = 1'b0;
    cpu_err   = 1'b0;
    cpu_busy  = (state_q != IDLE);
    case (state_q)
      ISSUE: begin
        mem_read  = !we_q;
        mem_write = we_q;
      end
      DONE:    cpu_done = 1'b1;
      ERR:     cpu_err  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    we_d     = we_q;
    word_d   = word_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    rdata_d  = rdata_q;
    if (state_q == IDLE && cpu_req) begin
      we_d    = cpu_we;
      word_d  = cpu_word;
      addr_d  = cpu_addr;
      wdata_d = cpu_wdata;
      idx_d   = 1'(LANE_LO);
    end
    if (state_q == WAIT && match) begin
      if (!we_q) begin
        if (idx_q == 1'(LANE_HI)) shadow_d[15:8] = mem_data_out;
        else                      shadow_d[7:0]  = mem_data_out;
        // Result becomes visible on entry to DONE; byte loads zero-extend.
        if (last_byte) rdata_d = word_q ? shadow_d : {8'h00, shadow_d[7:0]};
      end
      if (!last_byte) idx_d = idx_q + 1'b1;
    end
  end

  // NOTE: the shadow buffer is ordinary flops, not a RAM array, so it takes
  // the async reset along with the rest of the datapath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q     <= 1'b0;
      word_q   <= 1'b0;
      idx_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      shadow_q <= '0;
      rdata_q  <= '0;
    end else begin
      we_q     <= we_d;
      word_q   <= word_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      shadow_q <= shadow_d;
      rdata_q  <= rdata_d;
    end
  end

  // Address arithmetic wraps naturally at the address width.
  assign mem_address = addr_q + size_addr'(idx_q);
  assign mem_data_in = lane_byte(wdata_q, idx_q);
  assign cpu_rdata   = rdata_q;

endmodule

// File: tb/tb_mem_master.sv
// Scoreboard bench for mem_master: a driver predicts strobes and completions
// from a byte-array RAM model, a responder plays the RAM, monitors compare.
module tb_mem_master;

  localparam int SA = 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, cpu_word;
  logic [SA-1:0] cpu_addr;
  logic [15:0]   cpu_wdata;
  logic          cpu_busy, cpu_done, cpu_err;
  logic [15:0]   cpu_rdata;
  logic          mem_read, mem_write;
  logic [SA-1:0] mem_address;
  logic [7:0]    mem_data_in;
  logic [7:0]    mem_data_out = 8'h00;
  logic          mem_ready_r  = 1'b0;
  logic          mem_ready_w  = 1'b0;

  always #5 clk = ~clk;

  mem_master #(.size_addr(SA), .timeout(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_word     (cpu_word),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_busy     (cpu_busy),
    .cpu_done     (cpu_done),
    .cpu_err      (cpu_err),
    .cpu_rdata    (cpu_rdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .mem_ready_r  (mem_ready_r),
    .mem_ready_w  (mem_ready_w)
  );

  typedef struct { int cyc; bit err; logic [15:0] rdata; } resp_t;
  typedef struct { int cyc; bit we; logic [7:0] addr; logic [7:0] data; } strobe_t;

  resp_t       resp_q[$];
  strobe_t     strobe_q[$];
  int          lat_q[$];
  logic [7:0]  ram   [256];
  logic [7:0]  model [256];
  logic [15:0] model_rdata = 16'h0000;
  int          cyc = 0;
  int          vectors = 0;
  int          errors = 0;
  int          busy_lo = 1;
  int          busy_hi = 0;
  bit          checking = 1'b0;
  int          resp_cnt = 0;
  int          late_cnt = 0;
  int          resp_lat;
  bit          resp_we = 1'b0;
  logic [7:0]  resp_addr, resp_data;
  resp_t       mon_r;
  strobe_t     mon_s;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // RAM responder: lat N raises the matching ready in the N-th WAIT cycle,
  // lat 0 never completes (only a late, ignorable ready in the ERR cycle).
  always @(negedge clk) begin
    mem_ready_r  = 1'b0;
    mem_ready_w  = 1'b0;
    mem_data_out = 8'($urandom);
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        if (resp_we) begin
          ram[resp_addr] = resp_data;
          mem_ready_w = 1'b1;
        end else begin
          mem_data_out = ram[resp_addr];
          mem_ready_r  = 1'b1;
        end
      end
    end
    if (late_cnt > 0) begin
      late_cnt--;
      if (late_cnt == 0) begin
        if (resp_we) mem_ready_w = 1'b1;
        else         mem_ready_r = 1'b1;
      end
    end
    if (reset && (mem_read || mem_write)) begin
      resp_we   = mem_write;
      resp_addr = mem_address;
      resp_data = mem_data_in;
      resp_lat  = (lat_q.size() != 0) ? lat_q.pop_front() : 1;
      if (resp_lat == 0) begin
        resp_cnt = 0;
        late_cnt = TO + 1;
      end else begin
        resp_cnt = resp_lat;
      end
      if ($urandom_range(3) == 0) begin
        if (resp_we) mem_ready_w = 1'b1;
        else         mem_ready_r = 1'b1;
      end
    end
    if ($urandom_range(3) == 0) begin
      if (resp_we) mem_ready_r = 1'b1;
      else         mem_ready_w = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("busy", 32'(cpu_busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
      if (mem_read || mem_write) begin
        if (strobe_q.size() == 0) begin
          check("unexpected_strobe", 32'({mem_read, mem_write}), 32'd0);
        end else begin
          mon_s = strobe_q.pop_front();
          check("strobe_cycle", cyc, mon_s.cyc);
          check("strobe_kind", 32'({mem_read, mem_write}), mon_s.we ? 32'd1 : 32'd2);
          check("strobe_addr", 32'(mem_address), 32'(mon_s.addr));
          if (mon_s.we) check("strobe_wdata", 32'(mem_data_in), 32'(mon_s.data));
        end
      end else if (strobe_q.size() != 0 && strobe_q[0].cyc <= cyc) begin
        mon_s = strobe_q.pop_front();
        check("missing_strobe", cyc, mon_s.cyc - 1);
      end
      if (cpu_done || cpu_err) begin
        if (resp_q.size() == 0) begin
          check("unexpected_pulse", 32'({cpu_done, cpu_err}), 32'd0);
        end else begin
          mon_r = resp_q.pop_front();
          check("resp_cycle", cyc, mon_r.cyc);
          check("resp_kind", 32'({cpu_done, cpu_err}), mon_r.err ? 32'd1 : 32'd2);
          check("cpu_rdata", 32'(cpu_rdata), 32'(mon_r.rdata));
        end
      end else if (resp_q.size() != 0 && resp_q[0].cyc <= cyc) begin
        mon_r = resp_q.pop_front();
        check("missing_pulse", cyc, mon_r.cyc - 1);
      end
    end
  end

  // Called at negedge+1 of an IDLE cycle: request is accepted at the next edge.
  task automatic start_op(input bit we, input bit word, input logic [7:0] addr,
                          input logic [15:0] wdata, input int lat0, input int lat1,
                          output int e);
    int          a;
    int          s;
    int          lat;
    int          n;
    bit          err;
    logic [7:0]  ba;
    logic [7:0]  bd;
    logic [15:0] rd;
    a   = cyc + 1;
    s   = a;
    n   = word ? 2 : 1;
    err = 1'b0;
    rd  = model_rdata;
    e   = a;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_word  = word;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    for (int k = 0; k < n; k++) begin
      lat = (k == 0) ? lat0 : lat1;
      ba  = addr + 8'(k);
      bd  = (k == 0) ? wdata[7:0] : wdata[15:8];
      strobe_q.push_back('{cyc: s, we: we, addr: ba, data: bd});
      lat_q.push_back(lat);
      if (lat == 0) begin
        err = 1'b1;
        e   = s + TO + 1;
        break;
      end
      if (we)          model[ba] = bd;
      else if (k == 0) rd = {8'h00, model[ba]};
      else             rd[15:8] = model[ba];
      s = s + 1 + lat;
      e = s;
    end
    if (!err && !we) model_rdata = rd;
    resp_q.push_back('{cyc: e, err: err, rdata: model_rdata});
    busy_lo = a;
    busy_hi = e;
  endtask

  // Runs until the IDLE cycle after DONE/ERR; with hold, req stays high with
  // junk fields all through the busy window.
  task automatic finish_op(input int e, input bit hold);
    @(negedge clk); #1;
    while (cyc < e + 1) begin
      if (hold) begin
        cpu_req   = 1'b1;
        cpu_we    = 1'($urandom);
        cpu_word  = 1'($urandom);
        cpu_addr  = 8'($urandom);
        cpu_wdata = 16'($urandom);
      end else begin
        cpu_req = 1'b0;
      end
      @(negedge clk); #1;
    end
    cpu_req = 1'b0;
  endtask

  task automatic run_op(input bit we, input bit word, input logic [7:0] addr,
                        input logic [15:0] wdata, input int lat0, input int lat1,
                        input bit hold);
    int e;
    start_op(we, word, addr, wdata, lat0, lat1, e);
    finish_op(e, hold);
  endtask

  function automatic int pick_lat();
    int r;
    r = int'($urandom_range(9));
    if (r == 0) return 0;
    if (r == 1) return TO;
    return int'($urandom_range(3, 1));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e;
    logic [7:0] ra;
    reset     = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_word  = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      ram[i]   = 8'h00;
      model[i] = 8'h00;
    end
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", 32'({cpu_busy, cpu_done, cpu_err, mem_read, mem_write}), 32'd0);
    check("reset_rdata", 32'(cpu_rdata), 32'd0);
    check("reset_addr_data", 32'({mem_address, mem_data_in}), 32'd0);
    #1 reset = 1'b1;
    checking = 1'b1;
    @(negedge clk); #1;

    run_op(1'b1, 1'b0, 8'h10, 16'h005A, 1, 1, 1'b0);
    run_op(1'b0, 1'b0, 8'h10, 16'h0000, 1, 1, 1'b0);
    run_op(1'b1, 1'b1, 8'h20, 16'hBEEF, 1, 1, 1'b0);
    run_op(1'b0, 1'b1, 8'h20, 16'h0000, 1, 1, 1'b0);
    run_op(1'b1, 1'b1, 8'hFF, 16'h1234, 1, 1, 1'b0);
    run_op(1'b0, 1'b1, 8'hFF, 16'h0000, 1, 1, 1'b0);
    run_op(1'b1, 1'b0, 8'h30, 16'h00AA, 0, 1, 1'b0);
    run_op(1'b0, 1'b0, 8'h21, 16'h0000, TO, 1, 1'b0);

    // Reset in the middle of a word load.
    start_op(1'b0, 1'b1, 8'h20, 16'h0000, 3, 1, e);
    @(negedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    check("midop_reset_ctrl", 32'({cpu_busy, cpu_done, cpu_err, mem_read, mem_write}), 32'd0);
    check("midop_reset_rdata", 32'(cpu_rdata), 32'd0);
    check("midop_reset_addr_data", 32'({mem_address, mem_data_in}), 32'd0);
    resp_q.delete();
    strobe_q.delete();
    lat_q.delete();
    resp_cnt    = 0;
    late_cnt    = 0;
    busy_lo     = 1;
    busy_hi     = 0;
    model_rdata = 16'h0000;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk); #1;
    run_op(1'b0, 1'b0, 8'h10, 16'h0000, 1, 1, 1'b0);

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(3))
        0:       ra = 8'hFF;
        1:       ra = 8'h00;
        default: ra = 8'h10 + 8'($urandom_range(15));
      endcase
      run_op(1'($urandom), 1'($urandom), ra, 16'($urandom), pick_lat(), pick_lat(),
             1'($urandom_range(3) != 0));
      if (cpu_req == 1'b0 && $urandom_range(1) == 1) begin
        repeat ($urandom_range(2)) begin
          @(negedge clk); #1;
        end
      end
    end

    repeat (TO + 4) @(negedge clk);
    checking = 1'b0;
    check("pending_responses", resp_q.size(), 0);
    check("pending_strobes", strobe_q.size(), 0);
    for (int i = 0; i < 256; i++) begin
      check($sformatf("ram_%02h", i), 32'(ram[i]), 32'(model[i]));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
